signal_gen_ctrl: RTL and testbench

- Programmable square/PWM wave generator; the transmit-side counterpart of signal_measure_ctrl.
- Takes a target frequency in Hz and a duty cycle in percent, and converts them to clock-cycle high/low counts using a shared sequential divider.
- Emits a burst of N periods, or runs continuously, on sig_out.
- Used as an on-chip stimulus source and for loopback self-test against the measurement block.

---
 rtl/signal_pkg.sv | 15 +
 rtl/seq_divider.sv | 62 ++++++
 rtl/signal_gen_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_signal_gen_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/signal_pkg.sv
// Shared types and constants for the square/PWM signal generator.
package signal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC_PER,
    CALC_HIGH,
    RUN
  } state_e;

  localparam logic [7:0] DUTY_MAX  = 8'd100;
  localparam int         DIV_W     = 34;
  localparam int         PER_W_DEF = 26;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start edge, so done_o is high in the W-th cycle counted from the start cycle.
module seq_divider
  import signal_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic         done_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          act_q;

  logic [W-1:0] rem_src, quo_src, dvs_src, rem_nxt, quo_nxt;
  logic [W:0]   shifted;
  logic         ge;

  always_comb begin
    rem_src = start_i ? '0 : rem_q;
    quo_src = start_i ? dividend_i : quo_q;
    dvs_src = start_i ? divisor_i : dvs_q;
    shifted = {rem_src, quo_src[W-1]};
    ge      = (shifted >= {1'b0, dvs_src});
    rem_nxt = ge ? W'(shifted - {1'b0, dvs_src}) : shifted[W-1:0];
    quo_nxt = {quo_src[W-2:0], ge};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else if (start_i) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      dvs_q <= divisor_i;
      cnt_q <= CW'(W - 1);
      act_q <= 1'b1;
    end else if (act_q && cnt_q != '0) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CW'(1);
    end else begin
      act_q <= 1'b0;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = act_q && (cnt_q == '0);

endmodule

// File: rtl/signal_gen_ctrl.sv
// Square/PWM generator: divides the clock down to a period, splits it by duty,
// then emits a burst of periods (or runs continuously) on sig_out.
//   state     | meaning
//   IDLE      | waiting for start
//   CALC_PER  | divider computes CLK_FREQ / freq
//   CALC_HIGH | divider computes period * duty / 100
//   RUN       | waveform output, one phase timer plus period counter
module signal_gen_ctrl
  import signal_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PER_W    = PER_W_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [25:0]      freq,
  input  logic [7:0]       duty,
  input  logic [CNT_W-1:0] count,
  output logic             sig_out,
  output logic             busy,
  output logic             finish,
  output logic             err,
  output logic [PER_W-1:0] high_time,
  output logic [PER_W-1:0] low_time
);

  state_e             state_q, state_d;
  logic [7:0]         duty_q, duty_d;
  logic [CNT_W-1:0]   count_q, count_d, per_cnt_q, per_cnt_d, cnt_nxt;
  logic [PER_W-1:0]   period_q, period_d, high_q, high_d, low_q, low_d, tmr_q, tmr_d;
  logic               ph_high_q, ph_high_d, first_q, first_d;
  logic               sig_q, sig_d, fin_q, fin_d, err_q, err_d;

  logic               div_start, div_done;
  logic [DIV_W-1:0]   div_a, div_b, div_quo;

  seq_divider #(.W(DIV_W)) u_div (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (div_start),
    .dividend_i (div_a),
    .divisor_i  (div_b),
    .quotient_o (div_quo),
    .done_o     (div_done)
  );

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    count_d   = count_q;
    period_d  = period_q;
    high_d    = high_q;
    low_d     = low_q;
    tmr_d     = tmr_q;
    per_cnt_d = per_cnt_q;
    ph_high_d = ph_high_q;
    first_d   = first_q;
    sig_d     = sig_q;
    fin_d     = 1'b0;
    err_d     = 1'b0;
    div_start = 1'b0;
    div_a     = '0;
    div_b     = '0;
    cnt_nxt   = per_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (freq == '0) begin
            err_d = 1'b1;
          end else begin
            state_d   = CALC_PER;
            duty_d    = (duty > DUTY_MAX) ? DUTY_MAX : duty;
            count_d   = count;
            div_start = 1'b1;
            div_a     = DIV_W'(CLK_FREQ);
            div_b     = DIV_W'(freq);
          end
        end
      end
      CALC_PER: begin
        if (stop) begin
          state_d = IDLE;
        end else if (div_done) begin
          if (div_quo < DIV_W'(2)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            period_d  = PER_W'(div_quo);
            div_start = 1'b1;
            div_a     = div_quo * DIV_W'(duty_q);
            div_b     = DIV_W'(DUTY_MAX);
            state_d   = CALC_HIGH;
          end
        end
      end
      CALC_HIGH: begin
        if (stop) begin
          state_d = IDLE;
        end else if (div_done) begin
          high_d    = PER_W'(div_quo);
          low_d     = period_q - PER_W'(div_quo);
          tmr_d     = '0;
          per_cnt_d = '0;
          first_d   = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          sig_d   = 1'b0;
          state_d = IDLE;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - PER_W'(1);
        end else if (ph_high_q && !first_q && low_q != '0) begin
          sig_d     = 1'b0;
          ph_high_d = 1'b0;
          tmr_d     = low_q - PER_W'(1);
        end else begin
          // Period boundary; the very first boundary only opens period one.
          cnt_nxt   = first_q ? per_cnt_q : per_cnt_q + CNT_W'(1);
          per_cnt_d = cnt_nxt;
          first_d   = 1'b0;
          if (!first_q && count_q != '0 && cnt_nxt == count_q) begin
            sig_d   = 1'b0;
            fin_d   = 1'b1;
            state_d = IDLE;
          end else if (high_q != '0) begin
            sig_d     = 1'b1;
            ph_high_d = 1'b1;
            tmr_d     = high_q - PER_W'(1);
          end else begin
            sig_d     = 1'b0;
            ph_high_d = 1'b0;
            tmr_d     = low_q - PER_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      count_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      low_q     <= '0;
      tmr_q     <= '0;
      per_cnt_q <= '0;
      ph_high_q <= 1'b0;
      first_q   <= 1'b0;
      sig_q     <= 1'b0;
      fin_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      count_q   <= count_d;
      period_q  <= period_d;
      high_q    <= high_d;
      low_q     <= low_d;
      tmr_q     <= tmr_d;
      per_cnt_q <= per_cnt_d;
      ph_high_q <= ph_high_d;
      first_q   <= first_d;
      sig_q     <= sig_d;
      fin_q     <= fin_d;
      err_q     <= err_d;
    end
  end

  assign sig_out   = sig_q;
  assign busy      = (state_q != IDLE);
  assign finish    = fin_q;
  assign err       = err_q;
  assign high_time = high_q;
  assign low_time  = low_q;

endmodule

// File: tb/tb_signal_gen_ctrl.sv
// Directed bench for signal_gen_ctrl at the default 50 MHz clock.
module tb_signal_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [25:0] freq;
  logic [7:0]  duty;
  logic [15:0] count;
  logic        sig_out, busy, finish, err;
  logic [25:0] high_time, low_time;

  int total = 0;
  int bad   = 0;

  signal_gen_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .freq      (freq),
    .duty      (duty),
    .count     (count),
    .sig_out   (sig_out),
    .busy      (busy),
    .finish    (finish),
    .err       (err),
    .high_time (high_time),
    .low_time  (low_time)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ends #1 after the edge that samples start; inputs are then scrambled.
  task automatic start_op(input logic [25:0] f, input logic [7:0] d, input logic [15:0] c,
                          input logic sp);
    @(negedge clk);
    freq  = f;
    duty  = d;
    count = c;
    stop  = sp;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    freq  = 26'h3FF_FFFF;
    duty  = 8'd77;
    count = 16'd9;
  endtask

  // Expected {sig_out,busy,finish} for edges k_from..k_to after the start edge.
  task automatic follow(input string tag, input int P, input int H, input int c,
                        input int k_from, input int k_to);
    int endk;
    logic [2:0] e;
    endk = (c == 0) ? (1 << 30) : 69 + c * P;
    for (int k = k_from; k <= k_to; k++) begin
      @(posedge clk);
      #1;
      e[2] = (k >= 69) && (k < endk) && (((k - 69) % P) < H);
      e[1] = (k < endk);
      e[0] = (k == endk);
      chk($sformatf("%s k=%0d", tag, k), 64'({sig_out, busy, finish}), 64'(e));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    freq = '0; duty = '0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig", 64'(sig_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fin", 64'(finish), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_high", 64'(high_time), 64'd0);
    chk("rst_low", 64'(low_time), 64'd0);
    rst = 1'b0;

    // 500 kHz, 40 %, 3 periods: period 100, 40/60, finish at +369
    start_op(26'd500_000, 8'd40, 16'd3, 1'b0);
    chk("t1_k0", 64'({sig_out, busy, finish}), 64'(3'b010));
    follow("t1", 100, 40, 3, 1, 371);
    chk("t1_high", 64'(high_time), 64'd40);
    chk("t1_low", 64'(low_time), 64'd60);

    // 3 MHz, 33 %, 2 periods: period 16, 5/11; a start while busy is ignored
    start_op(26'd3_000_000, 8'd33, 16'd2, 1'b0);
    follow("t2", 16, 5, 2, 1, 20);
    start = 1'b1;
    freq  = 26'd1_000_000;
    follow("t2", 16, 5, 2, 21, 21);
    start = 1'b0;
    follow("t2", 16, 5, 2, 22, 103);
    chk("t2_high", 64'(high_time), 64'd5);
    chk("t2_low", 64'(low_time), 64'd11);

    // 1 MHz, duty 0, 4 periods; stop alongside start in IDLE loses to start
    start_op(26'd1_000_000, 8'd0, 16'd4, 1'b1);
    chk("t3_k0", 64'({sig_out, busy, finish}), 64'(3'b010));
    follow("t3", 50, 0, 4, 1, 271);
    chk("t3_high", 64'(high_time), 64'd0);
    chk("t3_low", 64'(low_time), 64'd50);

    // 1 MHz, duty 150 clamps to 100, 1 period: finish at +119 with sig_out low
    start_op(26'd1_000_000, 8'd150, 16'd1, 1'b0);
    follow("t4", 50, 50, 1, 1, 121);
    chk("t4_high", 64'(high_time), 64'd50);
    chk("t4_low", 64'(low_time), 64'd0);

    // freq 0: err one cycle after start, never busy
    start_op(26'd0, 8'd50, 16'd1, 1'b0);
    chk("e0_k0", 64'({sig_out, busy, err}), 64'(3'b001));
    @(posedge clk); #1;
    chk("e0_k1", 64'({sig_out, busy, err}), 64'(3'b000));

    // 30 MHz: period 1 is rejected after the first divide
    start_op(26'd30_000_000, 8'd50, 16'd1, 1'b0);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      chk($sformatf("e1 k=%0d", k), 64'({sig_out, busy, err}),
          64'((k < 34) ? 3'b010 : (k == 34) ? 3'b001 : 3'b000));
    end
    chk("e1_high_hold", 64'(high_time), 64'd50);
    chk("e1_low_hold", 64'(low_time), 64'd0);

    // Continuous 25/25; stop mid-high at +229
    start_op(26'd1_000_000, 8'd50, 16'd0, 1'b0);
    follow("c0", 50, 25, 0, 1, 229);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("c0_stop", 64'({sig_out, busy, finish}), 64'(3'b000));
    @(posedge clk); #1;
    chk("c0_after", 64'({sig_out, busy, finish, err}), 64'(4'b0000));
    chk("c0_high_hold", 64'(high_time), 64'd25);
    chk("c0_low_hold", 64'(low_time), 64'd25);

    // Stop on the same edge as the final period end: no finish
    start_op(26'd1_000_000, 8'd50, 16'd2, 1'b0);
    follow("sf", 50, 25, 2, 1, 168);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("sf_k169", 64'({sig_out, busy, finish}), 64'(3'b000));
    @(posedge clk); #1;
    chk("sf_k170", 64'({sig_out, busy, finish}), 64'(3'b000));

    // Reset in the middle of RUN
    start_op(26'd1_000_000, 8'd50, 16'd0, 1'b0);
    follow("rr", 50, 25, 0, 1, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rr_flags", 64'({sig_out, busy, finish, err}), 64'(4'b0000));
    chk("rr_high", 64'(high_time), 64'd0);
    chk("rr_low", 64'(low_time), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
